ram_req_ctrl: RTL
=================

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning RAM data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, command offered.
REQ-006 SHALL have port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_we, input, 1, 1 = write, 0 = read burst.
REQ-008 SHALL have port cmd_addr, input, ADDR_W, start address.
REQ-009 SHALL have port cmd_len, input, 4, read burst length minus one (1..16 words); ignored for writes.
REQ-010 SHALL have port cmd_wdata, input, DATA_W, write data.
REQ-011 SHALL have port rsp_valid, output, 1, read word available.
REQ-012 SHALL have port rsp_ready, input, 1, consumer takes the word.
REQ-013 SHALL have port rsp_rdata, output, DATA_W, read word.
REQ-014 SHALL have port rsp_addr, output, ADDR_W, address of rsp_rdata.
REQ-015 SHALL have port rsp_last, output, 1, final word of burst.
REQ-016 SHALL have RAM-side ports ram_we (output, 1), ram_write_address (output, ADDR_W), ram_read_address (output, ADDR_W), ram_data_in (output, DATA_W) and ram_data_out (input, DATA_W).

Function
REQ-017 SHALL implement FSM states IDLE, WR, RD_ISSUE, RD_CAPT, RD_HOLD.
REQ-018 SHALL assert cmd_ready only in IDLE; a handshake occurs on the edge where cmd_valid and cmd_ready are both high.
REQ-019 SHALL, on a write handshake, register the address and data, enter WR, drive ram_we=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL, on a read handshake, load the current address with cmd_addr and the remaining count with cmd_len, then enter RD_ISSUE.
REQ-021 SHALL, in RD_ISSUE, drive ram_we=0 and ram_read_address equal to the current address for one cycle, then enter RD_CAPT.
REQ-022 SHALL, in RD_CAPT, capture ram_data_out into rsp_rdata and the current address into rsp_addr, set rsp_last when the remaining count is 0, and enter RD_HOLD.
REQ-023 SHALL hold rsp_valid high throughout RD_HOLD, keeping rsp_rdata, rsp_addr and rsp_last stable until the rsp_ready handshake.
REQ-024 SHALL, on the rsp handshake, return to IDLE if the remaining count is 0; otherwise decrement the count, increment the address modulo 2^ADDR_W (0xFF wraps to 0x00) and enter RD_ISSUE.
REQ-025 SHALL give read latency of exactly 2 cycles from command-handshake edge to rsp_valid high, and 3 cycles per word when rsp_ready is held high.
REQ-026 SHALL keep ram_we=0 in every state except WR, so the RAM read-address register is never skipped during a read.
REQ-027 SHALL drive all RAM-side outputs and rsp outputs from registers, with no combinational path from cmd or rsp inputs.
REQ-028 SHALL ignore cmd inputs outside IDLE; commands are not queued.

Reset
REQ-029 SHALL, while rst_n is low and independent of clk, force state IDLE, cmd_ready=0, rsp_valid=0, rsp_last=0, ram_we=0, and clear all address, data and count registers to 0.
REQ-030 SHALL make cmd_ready high from the first rising edge after rst_n deasserts.
REQ-031 SHALL, on reset mid-burst or mid-write, abandon the operation without completing a pending RAM write.

Structure
REQ-032 SHALL place the state encoding and the widths ADDR_W, DATA_W and LEN_W=4 in a shared package ram_ctrl_pkg.
REQ-033 SHALL be a single module with no sub-modules; the bench instantiates syn_RAM alongside it.

Verification
REQ-034 SHALL cover this case: write 0x1234 to address 0x20, then read with len 0 -> one response, rsp_rdata=0x1234, rsp_addr=0x20, rsp_last=1, rsp_valid 2 cycles after accept.
REQ-035 SHALL cover this case: read burst from address 0x04 with len 3 and rsp_ready high -> responses 0x00AA, 0x00BB, 0x00CC, 0x00DD at 3-cycle spacing, with rsp_last only on the fourth.
REQ-036 SHALL cover this case: read burst from address 0xFE with len 2 -> rsp_addr sequence 0xFE, 0xFF, 0x00.
REQ-037 SHALL cover this case: rsp_ready low for 5 cycles during a burst -> rsp_valid and rsp_rdata stay stable, no word is lost, and no extra RAM read is issued.
REQ-038 SHALL cover this case: rst_n pulsed low during RD_HOLD of a burst of len 7 -> rsp_valid=0 immediately, cmd_ready=1 after release, and a subsequent write/read pair completes correctly.
REQ-039 SHALL cover this case: cmd_valid held high in non-IDLE states -> no second command is accepted until IDLE.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared widths and FSM encoding for the RAM request controller.
// Imported by ram_req_ctrl.
package ram_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_CAPT,
    RD_HOLD
  } state_t;

endpackage

// File: rtl/ram_req_ctrl.sv
// Command front-end for a synchronous RAM: single writes and
// read bursts returned one word at a time over a valid/ready port.
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic                r_last;

  logic                w_cmd_hs;
  logic                w_rsp_hs;

  assign w_cmd_hs = cmd_valid && r_cmd_ready;
  assign w_rsp_hs = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_rsp_addr  <= '0;
      r_last      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_cmd_hs) begin
            r_cmd_ready <= 1'b0;
            if (cmd_we) begin
              r_waddr <= cmd_addr;
              r_wdata <= cmd_wdata;
              r_we    <= 1'b1;
              r_state <= WR;
            end else begin
              r_addr  <= cmd_addr;
              r_cnt   <= cmd_len;
              r_state <= RD_ISSUE;
            end
          end
        end
        WR: begin
          r_we        <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        // r_addr doubles as the RAM read address, so it is already valid here
        RD_ISSUE: r_state <= RD_CAPT;
        RD_CAPT: begin
          r_rdata     <= ram_data_out;
          r_rsp_addr  <= r_addr;
          r_last      <= (r_cnt == '0);
          r_rsp_valid <= 1'b1;
          r_state     <= RD_HOLD;
        end
        RD_HOLD: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 1'b0;
            r_last      <= 1'b0;
            if (r_cnt == '0) begin
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_cnt   <= r_cnt - LEN_W'(1);
              r_addr  <= r_addr + ADDR_W'(1);
              r_state <= RD_ISSUE;
            end
          end
        end
        default: begin
          r_we        <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready         = r_cmd_ready;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_rdata         = r_rdata;
  assign rsp_addr          = r_rsp_addr;
  assign rsp_last          = r_last;
  assign ram_we            = r_we;
  assign ram_write_address = r_waddr;
  assign ram_read_address  = r_addr;
  assign ram_data_in       = r_wdata;

endmodule
